soc_mem_arbiter: RTL and testbench

- Parametrised N-master to single-memory-port arbiter for the SoC data RAM.
- Lets the pipeline core's data port share the RAM with additional masters (DMA, debug loader); it sits between those masters and the RAM instance at SoC top.
- Round-robin arbitration, optional lock for atomic read-modify-write, hold gating.
- Tracks read latency per master through a tag pipeline so each read response is routed back to its requester.

---
 rtl/soc_mem_arbiter_if.sv | 51 +++++
 rtl/soc_mem_arbiter.sv | 167 ++++++++++++++++
 tb/tb_soc_mem_arbiter.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/soc_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : soc_mem_arbiter_if
// Description : Bus bundle between the requesting masters / data RAM and the
//               soc_mem_arbiter. The "slave" modport is the arbiter's view.
//               The "master" modport is the environment's view, which covers
//               the requesting masters and the RAM instance.
//   m_req_i      per-master request
//   m_we_i       per-master write (1) / read (0)
//   m_lock_i     per-master lock (keep grant next cycle)
//   m_addr_i     packed addresses, master k at [k*ADDR_W +: ADDR_W]
//   m_wdata_i    packed write data, master k at [k*DATA_W +: DATA_W]
//   m_gnt_o      one-hot grant
//   m_rvalid_o   one-hot read-data-valid
//   m_rdata_o    shared read data, qualified by m_rvalid_o
//   mem_*        RAM read/write port
// Revision    : 1.0 - initial release
// ============================================================================
interface soc_mem_arbiter_if #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
);
    logic [NUM_MASTERS-1:0]        m_req_i;
    logic [NUM_MASTERS-1:0]        m_we_i;
    logic [NUM_MASTERS-1:0]        m_lock_i;
    logic [NUM_MASTERS*ADDR_W-1:0] m_addr_i;
    logic [NUM_MASTERS*DATA_W-1:0] m_wdata_i;
    logic [NUM_MASTERS-1:0]        m_gnt_o;
    logic [NUM_MASTERS-1:0]        m_rvalid_o;
    logic [DATA_W-1:0]             m_rdata_o;
    logic                          mem_r_ena_o;
    logic [ADDR_W-1:0]             mem_r_addr_o;
    logic                          mem_w_ena_o;
    logic [ADDR_W-1:0]             mem_w_addr_o;
    logic [DATA_W-1:0]             mem_w_data_o;
    logic [DATA_W-1:0]             mem_r_data_i;

    modport slave (
        input  m_req_i, m_we_i, m_lock_i, m_addr_i, m_wdata_i, mem_r_data_i,
        output m_gnt_o, m_rvalid_o, m_rdata_o,
               mem_r_ena_o, mem_r_addr_o, mem_w_ena_o, mem_w_addr_o, mem_w_data_o
    );

    modport master (
        output m_req_i, m_we_i, m_lock_i, m_addr_i, m_wdata_i, mem_r_data_i,
        input  m_gnt_o, m_rvalid_o, m_rdata_o,
               mem_r_ena_o, mem_r_addr_o, mem_w_ena_o, mem_w_addr_o, mem_w_data_o
    );
endinterface
`default_nettype wire

// File: rtl/soc_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : soc_mem_arbiter
// Description : N-master to single RAM port arbiter. Round-robin selection
//               with an optional per-master lock for atomic read-modify-write
//               sequences and a global hold. Reads are tracked through an
//               RD_LAT-deep tag pipeline so each response is steered back to
//               the master that issued it. One command per cycle, fully
//               pipelined.
// Ports       :
//   clk_100MHz  in   system clock
//   arst        in   asynchronous active-high reset, also gates all outputs
//   hold_i      in   suppress new grants (in-flight reads still complete)
//   bus         if   soc_mem_arbiter_if.slave (masters + RAM port)
//   busy_o      out  1 while any read is in flight
// Revision    : 1.0 - initial release
// ============================================================================
module soc_mem_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int RD_LAT      = 1
) (
    input  logic              clk_100MHz,
    input  logic              arst,
    input  logic              hold_i,
    soc_mem_arbiter_if.slave  bus,
    output logic              busy_o
);

    localparam int               IDX_W      = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NUM_MASTERS - 1);
    localparam logic [IDX_W-1:0] C_ONE      = IDX_W'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [IDX_W-1:0]             ptr_q,      ptr_d;
    logic                         lock_vld_q, lock_vld_d;
    logic [IDX_W-1:0]             lock_id_q,  lock_id_d;
    logic [RD_LAT-1:0]            tag_vld_q,  tag_vld_d;
    logic [RD_LAT-1:0][IDX_W-1:0] tag_id_q,   tag_id_d;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic              w_lock_hit;
    logic              w_found;
    logic              w_gnt_vld;
    logic [IDX_W-1:0]  w_gnt_idx;
    logic [IDX_W-1:0]  w_cand;
    logic              w_sel_we;
    logic              w_sel_lock;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic              w_rsp_vld;

    always_comb begin : arbitrate
        // A valid lock owner that keeps requesting wins outright.
        w_lock_hit = lock_vld_q && bus.m_req_i[lock_id_q];

        // Round-robin scan starting at the pointer; the candidate index
        // wraps explicitly so non-power-of-two master counts stay in range.
        w_found   = 1'b0;
        w_gnt_idx = '0;
        w_cand    = ptr_q;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!w_found && bus.m_req_i[w_cand]) begin
                w_found   = 1'b1;
                w_gnt_idx = w_cand;
            end
            w_cand = (w_cand == C_LAST_IDX) ? '0 : w_cand + C_ONE;
        end
        if (w_lock_hit) begin
            w_gnt_idx = lock_id_q;
        end

        w_gnt_vld = !arst && !hold_i && w_found;

        // Command mux for the selected master.
        w_sel_we    = 1'b0;
        w_sel_lock  = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (w_gnt_idx == IDX_W'(k)) begin
                w_sel_we    = bus.m_we_i[k];
                w_sel_lock  = bus.m_lock_i[k];
                w_sel_addr  = bus.m_addr_i[k*ADDR_W +: ADDR_W];
                w_sel_wdata = bus.m_wdata_i[k*DATA_W +: DATA_W];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs (all forced low while reset is asserted)
    // ------------------------------------------------------------------
    always_comb begin : drive_outputs
        w_rsp_vld = !arst && tag_vld_q[RD_LAT-1];

        bus.m_gnt_o    = '0;
        bus.m_rvalid_o = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            bus.m_gnt_o[k]    = w_gnt_vld && (w_gnt_idx == IDX_W'(k));
            bus.m_rvalid_o[k] = w_rsp_vld && (tag_id_q[RD_LAT-1] == IDX_W'(k));
        end
        bus.m_rdata_o    = w_rsp_vld ? bus.mem_r_data_i : '0;

        bus.mem_r_ena_o  = w_gnt_vld && !w_sel_we;
        bus.mem_r_addr_o = (w_gnt_vld && !w_sel_we) ? w_sel_addr  : '0;
        bus.mem_w_ena_o  = w_gnt_vld &&  w_sel_we;
        bus.mem_w_addr_o = (w_gnt_vld &&  w_sel_we) ? w_sel_addr  : '0;
        bus.mem_w_data_o = (w_gnt_vld &&  w_sel_we) ? w_sel_wdata : '0;

        busy_o = !arst && (|tag_vld_q);
    end

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin : next_state
        ptr_d      = ptr_q;
        lock_vld_d = lock_vld_q;
        lock_id_d  = lock_id_q;

        if (w_gnt_vld) begin
            // Locked grants do not advance the pointer, so fairness resumes
            // from where it was once the lock is released.
            if (!w_lock_hit) begin
                ptr_d = (w_gnt_idx == C_LAST_IDX) ? '0 : w_gnt_idx + C_ONE;
            end
            lock_vld_d = w_sel_lock;
            lock_id_d  = w_gnt_idx;
        end else if (lock_vld_q && !bus.m_req_i[lock_id_q]) begin
            // Owner walked away (also during hold): release the lock.
            lock_vld_d = 1'b0;
        end

        // Tag pipeline shifts every cycle regardless of hold.
        tag_vld_d = tag_vld_q;
        tag_id_d  = tag_id_q;
        for (int i = RD_LAT - 1; i > 0; i--) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_id_d[i]  = tag_id_q[i-1];
        end
        tag_vld_d[0] = w_gnt_vld && !w_sel_we;
        tag_id_d[0]  = w_gnt_idx;
    end

    always_ff @(posedge clk_100MHz or posedge arst) begin
        if (arst) begin
            ptr_q      <= '0;
            lock_vld_q <= 1'b0;
            lock_id_q  <= '0;
            tag_vld_q  <= '0;
            tag_id_q   <= '0;
        end else begin
            ptr_q      <= ptr_d;
            lock_vld_q <= lock_vld_d;
            lock_id_q  <= lock_id_d;
            tag_vld_q  <= tag_vld_d;
            tag_id_q   <= tag_id_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_soc_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_soc_mem_arbiter
// Description : Randomised self-checking bench for soc_mem_arbiter with three
//               masters and a two-cycle RAM. A transaction-level model
//               (pending requests, pointer, lock owner, queue of due
//               responses) predicts grants, RAM commands and read responses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_soc_mem_arbiter;

    localparam int N    = 3;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int LAT  = 2;
    localparam int NCYC = 3000;

    logic clk  = 1'b0;
    logic arst = 1'b1;
    logic hold = 1'b0;
    logic busy;

    soc_mem_arbiter_if #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    soc_mem_arbiter #(
        .NUM_MASTERS (N),
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .RD_LAT      (LAT)
    ) dut (
        .clk_100MHz (clk),
        .arst       (arst),
        .hold_i     (hold),
        .bus        (bus),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // RAM model: fixed contents, LAT-cycle read pipeline
    // ------------------------------------------------------------------
    function automatic logic [DW-1:0] ram_word(input logic [AW-1:0] a);
        if (a == 32'h10) return 32'hDEADBEEF;
        return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    logic [DW-1:0] ram_pipe [LAT];
    always @(posedge clk) begin
        ram_pipe[0] <= bus.mem_r_ena_o ? ram_word(bus.mem_r_addr_o) : '0;
        for (int i = 1; i < LAT; i++) ram_pipe[i] <= ram_pipe[i-1];
    end
    assign bus.mem_r_data_i = ram_pipe[LAT-1];

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model state
    // ------------------------------------------------------------------
    typedef struct {
        int            due;
        int            id;
        logic [DW-1:0] data;
    } rsp_t;

    rsp_t          rsp_q[$];
    int            ptr      = 0;
    int            lock_own = -1;
    bit            pend   [N];
    bit            we_r   [N];
    bit            lock_r [N];
    logic [AW-1:0] addr_r [N];
    logic [DW-1:0] wd_r   [N];

    task automatic model_step();
        int            g;
        bit            via_lock;
        bit            any_req;
        bit            popped;
        logic [N-1:0]  exp_gnt;
        logic [N-1:0]  exp_rv;
        logic [DW-1:0] exp_rd;
        rsp_t          r;

        if (arst) begin
            chk("rst_gnt",    bus.m_gnt_o,      '0);
            chk("rst_rvalid", bus.m_rvalid_o,   '0);
            chk("rst_rdata",  bus.m_rdata_o,    '0);
            chk("rst_r_ena",  bus.mem_r_ena_o,  '0);
            chk("rst_w_ena",  bus.mem_w_ena_o,  '0);
            chk("rst_r_addr", bus.mem_r_addr_o, '0);
            chk("rst_w_addr", bus.mem_w_addr_o, '0);
            chk("rst_w_data", bus.mem_w_data_o, '0);
            chk("rst_busy",   busy,             '0);
            rsp_q.delete();
            ptr      = 0;
            lock_own = -1;
            return;
        end

        // Who should win this cycle.
        g        = -1;
        via_lock = 1'b0;
        any_req  = 1'b0;
        for (int k = 0; k < N; k++) if (pend[k]) any_req = 1'b1;
        if (!hold && any_req) begin
            if (lock_own >= 0 && pend[lock_own]) begin
                g        = lock_own;
                via_lock = 1'b1;
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (g < 0 && pend[(ptr + i) % N]) g = (ptr + i) % N;
                end
            end
        end

        // Response due this cycle.
        popped = 1'b0;
        exp_rv = '0;
        exp_rd = '0;
        if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
            exp_rv[rsp_q[0].id] = 1'b1;
            exp_rd = rsp_q[0].data;
            void'(rsp_q.pop_front());
            popped = 1'b1;
        end
        chk("rvalid", bus.m_rvalid_o, exp_rv);
        if (popped) chk("rdata", bus.m_rdata_o, exp_rd);
        chk("busy", busy, popped || (rsp_q.size() > 0));

        exp_gnt = '0;
        if (g >= 0) exp_gnt[g] = 1'b1;
        chk("gnt", bus.m_gnt_o, exp_gnt);

        if (g < 0) begin
            chk("r_ena_idle",  bus.mem_r_ena_o,  '0);
            chk("w_ena_idle",  bus.mem_w_ena_o,  '0);
            chk("r_addr_idle", bus.mem_r_addr_o, '0);
            chk("w_addr_idle", bus.mem_w_addr_o, '0);
            chk("w_data_idle", bus.mem_w_data_o, '0);
            if (lock_own >= 0 && !pend[lock_own]) lock_own = -1;
        end else begin
            if (we_r[g]) begin
                chk("w_ena",  bus.mem_w_ena_o,  1);
                chk("r_ena",  bus.mem_r_ena_o,  0);
                chk("w_addr", bus.mem_w_addr_o, addr_r[g]);
                chk("w_data", bus.mem_w_data_o, wd_r[g]);
            end else begin
                chk("r_ena",  bus.mem_r_ena_o,  1);
                chk("w_ena",  bus.mem_w_ena_o,  0);
                chk("r_addr", bus.mem_r_addr_o, addr_r[g]);
                r.due  = cyc + LAT;
                r.id   = g;
                r.data = ram_word(addr_r[g]);
                rsp_q.push_back(r);
            end
            if (!via_lock) ptr = (g + 1) % N;
            lock_own = lock_r[g] ? g : -1;
            pend[g]  = 1'b0;
        end
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic drive_inputs();
        for (int k = 0; k < N; k++) begin
            bus.m_req_i[k] = pend[k];
            if (pend[k]) begin
                bus.m_we_i[k]                = we_r[k];
                bus.m_lock_i[k]              = lock_r[k];
                bus.m_addr_i[k*AW +: AW]     = addr_r[k];
                bus.m_wdata_i[k*DW +: DW]    = wd_r[k];
            end else begin
                // Idle masters present junk that must not leak through.
                bus.m_we_i[k]                = 1'($urandom_range(0, 1));
                bus.m_lock_i[k]              = 1'($urandom_range(0, 1));
                bus.m_addr_i[k*AW +: AW]     = $urandom;
                bus.m_wdata_i[k*DW +: DW]    = $urandom;
            end
        end
    endtask

    initial begin
        int req_pct;

        for (int k = 0; k < N; k++) begin
            pend[k] = 1'b0; we_r[k] = 1'b0; lock_r[k] = 1'b0;
            addr_r[k] = '0; wd_r[k] = '0;
        end
        // First transaction: master 0 reads the word at 0x10.
        pend[0]   = 1'b1;
        addr_r[0] = 32'h10;
        drive_inputs();

        arst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        model_step();

        for (cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clk);
            #1;
            arst = ((cyc % 500) >= 250) && ((cyc % 500) < 252);
            hold = (cyc > 0) && ($urandom_range(0, 7) == 0);
            req_pct = (cyc < 1000) ? 90 : 40;
            for (int k = 0; k < N; k++) begin
                if (cyc > 0 && !pend[k] && $urandom_range(0, 99) < req_pct) begin
                    pend[k]   = 1'b1;
                    we_r[k]   = ($urandom_range(0, 2) == 0);
                    lock_r[k] = ($urandom_range(0, 3) == 0);
                    addr_r[k] = $urandom;
                    wd_r[k]   = $urandom;
                end
            end
            drive_inputs();
            @(negedge clk);
            model_step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
